// File: rtl/matrix_input_parser_if.sv
// Handshake and result bundle between the UART-side controller and the matrix parser.
`timescale 1ns/1ps
interface matrix_input_parser_if #(
  parameter int MAX_ROWS = 5,
  parameter int MAX_COLS = 5
);
  typedef struct packed {
    logic [7:0]                               rows;
    logic [7:0]                               cols;
    logic                                     is_valid;
    logic [MAX_ROWS-1:0][MAX_COLS-1:0][7:0]   cells;
  } matrix_t;

  logic       start;
  logic       abort;
  logic       rx_valid;
  logic [7:0] rx_data;
  matrix_t    mat_out;
  logic       mat_valid;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output start, abort, rx_valid, rx_data,
    input  mat_out, mat_valid, busy, err, err_code
  );

  modport slave (
    input  start, abort, rx_valid, rx_data,
    output mat_out, mat_valid, busy, err, err_code
  );
endinterface

// File: rtl/matrix_input_parser.sv
// Parses "rows cols e0 e1 ..." ASCII tokens into a row-major matrix of signed bytes.
// States: IDLE wait | GET_ROWS/GET_COLS dimensions | GET_ELEMS cells | DONE/ERROR one-cycle pulse.
`timescale 1ns/1ps
module matrix_input_parser #(
  parameter int MAX_ROWS = 5,
  parameter int MAX_COLS = 5,
  parameter int VAL_MIN  = 0,
  parameter int VAL_MAX  = 9
) (
  input logic                  clk,
  input logic                  rst,
  matrix_input_parser_if.slave bus
);
  localparam int RW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
  localparam int CW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [9:0]         MAX_R = 10'(MAX_ROWS);
  localparam logic [9:0]         MAX_C = 10'(MAX_COLS);
  localparam logic signed [10:0] VMIN  = 11'(VAL_MIN);
  localparam logic signed [10:0] VMAX  = 11'(VAL_MAX);
  localparam logic [1:0] ERR_DIM   = 2'd1;
  localparam logic [1:0] ERR_CHAR  = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  typedef enum logic [2:0] {IDLE, GET_ROWS, GET_COLS, GET_ELEMS, DONE, ERROR} state_t;

  typedef struct packed {
    logic [7:0]                               rows;
    logic [7:0]                               cols;
    logic                                     is_valid;
    logic [MAX_ROWS-1:0][MAX_COLS-1:0][7:0]   cells;
  } mat_t;

  state_t        state_q, state_d;
  mat_t          mat_q, mat_d;
  logic [9:0]    acc_q, acc_d;
  logic          neg_q, neg_d;
  logic [1:0]    ndig_q, ndig_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic          stored_q, stored_d;
  logic [1:0]    err_code_q, err_code_d;

  logic              is_digit, is_delim, is_lf, is_minus, pending;
  logic              last_r, last_c;
  logic [3:0]        digit;
  logic signed [10:0] mag, val;
  logic              raise, finish;
  logic [1:0]        code;

  assign digit    = bus.rx_data[3:0];
  assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign is_lf    = (bus.rx_data == 8'h0A);
  assign is_delim = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) || is_lf;
  assign is_minus = (bus.rx_data == 8'h2D);
  assign pending  = neg_q || (ndig_q != 2'd0);
  assign mag      = {1'b0, acc_q};
  assign val      = neg_q ? -mag : mag;
  assign last_r   = (8'(r_q) == mat_q.rows - 8'd1);
  assign last_c   = (8'(c_q) == mat_q.cols - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mat_q      <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      ndig_q     <= '0;
      r_q        <= '0;
      c_q        <= '0;
      stored_q   <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      mat_q      <= mat_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      ndig_q     <= ndig_d;
      r_q        <= r_d;
      c_q        <= c_d;
      stored_q   <= stored_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mat_d      = mat_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    ndig_d     = ndig_q;
    r_d        = r_q;
    c_d        = c_q;
    stored_d   = stored_q;
    err_code_d = err_code_q;
    raise      = 1'b0;
    finish     = 1'b0;
    code       = ERR_CHAR;

    // start beats abort and drops any byte arriving in the same cycle
    if (bus.start) begin
      state_d    = GET_ROWS;
      mat_d      = '0;
      acc_d      = '0;
      neg_d      = 1'b0;
      ndig_d     = '0;
      r_d        = '0;
      c_d        = '0;
      stored_d   = 1'b0;
      err_code_d = '0;
    end else if (bus.abort) begin
      state_d = IDLE;
      acc_d   = '0;
      neg_d   = 1'b0;
      ndig_d  = '0;
    end else begin
      case (state_q)
        DONE, ERROR: state_d = IDLE;
        GET_ROWS, GET_COLS, GET_ELEMS: begin
          if (bus.rx_valid) begin
            if (is_digit) begin
              if (ndig_q == 2'd3) begin
                raise = 1'b1;
                code  = ERR_RANGE;
              end else begin
                acc_d  = acc_q * 10'd10 + {6'd0, digit};
                ndig_d = ndig_q + 2'd1;
              end
            end else if (is_minus) begin
              if (pending) raise = 1'b1;
              else         neg_d = 1'b1;
            end else if (is_delim) begin
              acc_d  = '0;
              neg_d  = 1'b0;
              ndig_d = '0;
              if (pending) begin
                if (ndig_q == 2'd0) begin
                  raise = 1'b1;
                end else if (state_q == GET_ROWS) begin
                  if (neg_q || acc_q == 10'd0 || acc_q > MAX_R) begin
                    raise = 1'b1;
                    code  = ERR_DIM;
                  end else begin
                    mat_d.rows = acc_q[7:0];
                    state_d    = GET_COLS;
                  end
                end else if (state_q == GET_COLS) begin
                  if (neg_q || acc_q == 10'd0 || acc_q > MAX_C) begin
                    raise = 1'b1;
                    code  = ERR_DIM;
                  end else begin
                    mat_d.cols = acc_q[7:0];
                    state_d    = GET_ELEMS;
                  end
                end else if (val < VMIN || val > VMAX) begin
                  raise = 1'b1;
                  code  = ERR_RANGE;
                end else begin
                  mat_d.cells[r_q][c_q] = val[7:0];
                  stored_d = 1'b1;
                  if ((last_r && last_c) || is_lf) begin
                    finish = 1'b1;
                  end else if (last_c) begin
                    c_d = '0;
                    r_d = r_q + 1'b1;
                  end else begin
                    c_d = c_q + 1'b1;
                  end
                end
              end else if (is_lf && state_q == GET_ELEMS && stored_q) begin
                finish = 1'b1;
              end
            end else begin
              raise = 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (raise) begin
        state_d    = ERROR;
        err_code_d = code;
      end else if (finish) begin
        state_d        = DONE;
        mat_d.is_valid = 1'b1;
      end
    end
  end

  assign bus.mat_out   = mat_q;
  assign bus.mat_valid = (state_q == DONE);
  assign bus.err       = (state_q == ERROR);
  assign bus.busy      = (state_q == GET_ROWS) || (state_q == GET_COLS) || (state_q == GET_ELEMS);
  assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_matrix_input_parser.sv
// Two parser instances (default limits and a wider/negative-capable set) fed the same
// byte stream, compared every cycle against a token-level model of the entry rules.
`timescale 1ns/1ps
module tb_matrix_input_parser;
  localparam int NI  = 2;
  localparam int MR0 = 5, MC0 = 5, VN0 = 0,  VX0 = 9;
  localparam int MR1 = 4, MC1 = 6, VN1 = -3, VX1 = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_input_parser_if #(.MAX_ROWS(MR0), .MAX_COLS(MC0)) bus0 ();
  matrix_input_parser_if #(.MAX_ROWS(MR1), .MAX_COLS(MC1)) bus1 ();

  matrix_input_parser #(.MAX_ROWS(MR0), .MAX_COLS(MC0), .VAL_MIN(VN0), .VAL_MAX(VX0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  matrix_input_parser #(.MAX_ROWS(MR1), .MAX_COLS(MC1), .VAL_MIN(VN1), .VAL_MAX(VX1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;
  int p_mr[NI], p_mc[NI], p_vn[NI], p_vx[NI];

  // model: phase 0 idle, 1 rows, 2 cols, 3 elements; k = elements stored so far
  int m_ph[NI], m_neg[NI], m_dig[NI], m_mag[NI];
  int m_rows[NI], m_cols[NI], m_k[NI], m_isv[NI], m_ec[NI], m_mv[NI], m_er[NI];
  int m_cell[NI][8][8];
  int mv_cnt[NI], er_cnt[NI];

  int d_busy, d_mv, d_er, d_ec, d_rows, d_cols, d_isv;
  int d_cell[8][8];
  byte unsigned q[$];

  task automatic chk(int i, string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0d, expected %0d (t=%0t)", i, nm, act, exp, $time);
    end
  endtask

  task automatic m_clear(int i);
    m_neg[i] = 0; m_dig[i] = 0; m_mag[i] = 0;
    m_rows[i] = 0; m_cols[i] = 0; m_k[i] = 0; m_isv[i] = 0; m_ec[i] = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m_cell[i][r][c] = 0;
  endtask

  task automatic m_fail(int i, int code);
    m_ph[i] = 0; m_er[i] = 1; m_ec[i] = code;
  endtask

  task automatic m_finish(int i);
    m_ph[i] = 0; m_mv[i] = 1; m_isv[i] = 1;
  endtask

  task automatic m_close(int i);
    int v, lim;
    if (m_dig[i] == 0) begin
      m_fail(i, 2);
      return;
    end
    v = m_neg[i] ? -m_mag[i] : m_mag[i];
    if (m_ph[i] == 1 || m_ph[i] == 2) begin
      lim = (m_ph[i] == 1) ? p_mr[i] : p_mc[i];
      if (m_neg[i] != 0 || v < 1 || v > lim) m_fail(i, 1);
      else if (m_ph[i] == 1) begin m_rows[i] = v; m_ph[i] = 2; end
      else begin m_cols[i] = v; m_ph[i] = 3; end
    end else begin
      if (v < p_vn[i] || v > p_vx[i]) m_fail(i, 3);
      else begin
        m_cell[i][m_k[i] / m_cols[i]][m_k[i] % m_cols[i]] = v & 255;
        m_k[i]++;
        if (m_k[i] == m_rows[i] * m_cols[i]) m_finish(i);
      end
    end
  endtask

  task automatic m_step(int i, bit r, bit s, bit a, bit v, byte unsigned d);
    m_mv[i] = 0; m_er[i] = 0;
    if (r) begin m_ph[i] = 0; m_clear(i); return; end
    if (s) begin m_ph[i] = 1; m_clear(i); return; end
    if (a) begin m_ph[i] = 0; m_neg[i] = 0; m_dig[i] = 0; m_mag[i] = 0; return; end
    if (!v || m_ph[i] == 0) return;
    if (d >= 8'd48 && d <= 8'd57) begin
      if (m_dig[i] == 3) m_fail(i, 3);
      else begin m_mag[i] = m_mag[i] * 10 + (int'(d) - 48); m_dig[i]++; end
    end else if (d == 8'h2D) begin
      if (m_neg[i] != 0 || m_dig[i] > 0) m_fail(i, 2);
      else m_neg[i] = 1;
    end else if (d == 8'h20 || d == 8'h0D || d == 8'h0A) begin
      if (m_neg[i] != 0 || m_dig[i] > 0) begin
        m_close(i);
        m_neg[i] = 0; m_dig[i] = 0; m_mag[i] = 0;
      end
      if (d == 8'h0A && m_ph[i] == 3 && m_k[i] > 0) m_finish(i);
    end else begin
      m_fail(i, 2);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) d_cell[r][c] = 0;
      if (i == 0) begin
        d_busy = int'(bus0.busy); d_mv = int'(bus0.mat_valid); d_er = int'(bus0.err);
        d_ec = int'(bus0.err_code); d_rows = int'(bus0.mat_out.rows);
        d_cols = int'(bus0.mat_out.cols); d_isv = int'(bus0.mat_out.is_valid);
        for (int r = 0; r < MR0; r++)
          for (int c = 0; c < MC0; c++) d_cell[r][c] = int'(bus0.mat_out.cells[r][c]);
      end else begin
        d_busy = int'(bus1.busy); d_mv = int'(bus1.mat_valid); d_er = int'(bus1.err);
        d_ec = int'(bus1.err_code); d_rows = int'(bus1.mat_out.rows);
        d_cols = int'(bus1.mat_out.cols); d_isv = int'(bus1.mat_out.is_valid);
        for (int r = 0; r < MR1; r++)
          for (int c = 0; c < MC1; c++) d_cell[r][c] = int'(bus1.mat_out.cells[r][c]);
      end
      if (d_mv != 0) mv_cnt[i]++;
      if (d_er != 0) er_cnt[i]++;
      chk(i, "busy", d_busy, (m_ph[i] != 0) ? 1 : 0);
      chk(i, "mat_valid", d_mv, m_mv[i]);
      chk(i, "err", d_er, m_er[i]);
      chk(i, "err_code", d_ec, m_ec[i]);
      chk(i, "rows", d_rows, m_rows[i]);
      chk(i, "cols", d_cols, m_cols[i]);
      chk(i, "is_valid", d_isv, m_isv[i]);
      for (int r = 0; r < p_mr[i]; r++)
        for (int c = 0; c < p_mc[i]; c++) chk(i, "cell", d_cell[r][c], m_cell[i][r][c]);
    end
  endtask

  task automatic tick(bit r, bit s, bit a, bit v, byte unsigned d);
    @(negedge clk);
    compare_all();
    rst = r;
    bus0.start = s; bus0.abort = a; bus0.rx_valid = v; bus0.rx_data = d;
    bus1.start = s; bus1.abort = a; bus1.rx_valid = v; bus1.rx_data = d;
    for (int i = 0; i < NI; i++) m_step(i, r, s, a, v, d);
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(string s);
    for (int j = 0; j < s.len(); j++) tick(1'b0, 1'b0, 1'b0, 1'b1, s[j]);
  endtask

  task automatic push_str(string s);
    for (int j = 0; j < s.len(); j++) q.push_back(s[j]);
  endtask

  task automatic push_sep();
    int x;
    x = $urandom_range(0, 9);
    if (x < 6) q.push_back(8'h20);
    else if (x < 8) q.push_back(8'h0D);
    else begin q.push_back(8'h20); q.push_back(8'h20); end
  endtask

  task automatic push_dim();
    int x;
    x = $urandom_range(0, 19);
    if (x == 0) push_str("-2");
    else if (x == 1) push_str("0");
    else if (x == 2) push_str("7");
    else if (x == 3) q.push_back(8'h0A);
    else push_str($sformatf("%0d", $urandom_range(1, 5)));
    push_sep();
  endtask

  task automatic push_elem();
    int x;
    x = $urandom_range(0, 99);
    if (x < 62) push_str($sformatf("%0d", $urandom_range(0, 9)));
    else if (x < 76) push_str($sformatf("%0d", int'($urandom_range(0, 16)) - 4));
    else if (x < 79) push_str($sformatf("%0d", $urandom_range(1000, 1500)));
    else if (x < 82) push_str($sformatf("%0d", $urandom_range(100, 999)));
    else if (x < 85) push_str("3x");
    else if (x < 87) push_str("-");
    else if (x < 89) push_str("4-1");
    else if (x < 91) q.push_back(8'hFF);
    else q.push_back(8'h0A);
    push_sep();
  endtask

  task automatic run_random_msg();
    int n, x;
    tick(1'b0, 1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), 8'h31);
    q.delete();
    push_dim();
    push_dim();
    n = $urandom_range(0, 26);
    for (int e = 0; e < n; e++) push_elem();
    foreach (q[j]) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      x = $urandom_range(0, 299);
      if (x < 2)       tick(1'b1, 1'b0, 1'b0, 1'b1, q[j]);
      else if (x < 6)  tick(1'b0, 1'b0, 1'b1, ($urandom_range(0, 1) == 1), q[j]);
      else if (x < 8)  tick(1'b0, 1'b1, 1'b0, 1'b1, q[j]);
      else             tick(1'b0, 1'b0, 1'b0, 1'b1, q[j]);
    end
    idle($urandom_range(1, 3));
  endtask

  int s_mv, s_er;

  initial begin
    p_mr[0] = MR0; p_mc[0] = MC0; p_vn[0] = VN0; p_vx[0] = VX0;
    p_mr[1] = MR1; p_mc[1] = MC1; p_vn[1] = VN1; p_vx[1] = VX1;
    rst = 1'b1;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.rx_valid = 1'b0; bus0.rx_data = 8'h00;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.rx_valid = 1'b0; bus1.rx_data = 8'h00;
    for (int i = 0; i < NI; i++) begin
      mv_cnt[i] = 0; er_cnt[i] = 0; m_ph[i] = 0; m_mv[i] = 0; m_er[i] = 0; m_clear(i);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);
    chk(0, "rst_busy", int'(bus0.busy), 0);
    chk(0, "rst_err_code", int'(bus0.err_code), 0);
    chk(0, "rst_rows", int'(bus0.mat_out.rows), 0);

    // bytes in IDLE are ignored
    send("1 1 5\n");
    idle(1);
    chk(0, "idle_ignore_mv", mv_cnt[0], 0);

    s_mv = mv_cnt[0];
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("2 3 1 2 3 4 5 6 ");
    idle(2);
    chk(0, "full_mv_count", mv_cnt[0] - s_mv, 1);
    chk(0, "full_rows", int'(bus0.mat_out.rows), 2);
    chk(0, "full_cols", int'(bus0.mat_out.cols), 3);
    chk(0, "full_cell12", int'(bus0.mat_out.cells[1][2]), 6);
    chk(0, "full_cell00", int'(bus0.mat_out.cells[0][0]), 1);
    chk(0, "full_cell20", int'(bus0.mat_out.cells[2][0]), 0);
    chk(0, "full_is_valid", int'(bus0.mat_out.is_valid), 1);
    send("9 9 ");
    chk(0, "post_done_stable", int'(bus0.mat_out.cells[1][2]), 6);

    s_mv = mv_cnt[0];
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("3 3 1 2\n");
    idle(2);
    chk(0, "lf_mv_count", mv_cnt[0] - s_mv, 1);
    chk(0, "lf_cell01", int'(bus0.mat_out.cells[0][1]), 2);
    chk(0, "lf_cell10", int'(bus0.mat_out.cells[1][0]), 0);

    s_er = er_cnt[0];
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("6 ");
    idle(1);
    chk(0, "dim_hi_err_pulse", er_cnt[0] - s_er, 1);
    chk(0, "dim_hi_busy", int'(bus0.busy), 0);
    chk(0, "dim_hi_code", int'(bus0.err_code), 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("0 ");
    idle(2);
    chk(0, "dim_zero_code", int'(bus0.err_code), 1);

    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("1 1 12 ");
    idle(2);
    chk(0, "range_code", int'(bus0.err_code), 3);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("1 1 -3\n");
    idle(2);
    chk(1, "neg_cell00", int'(bus1.mat_out.cells[0][0]), 8'hFD);
    chk(0, "neg_default_code", int'(bus0.err_code), 3);

    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("2 2 1a");
    idle(1);
    chk(0, "char_err", int'(bus0.err), 1);
    chk(0, "char_code", int'(bus0.err_code), 2);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("1 1 100");
    tick(1'b0, 1'b0, 1'b0, 1'b1, 8'h30);
    chk(0, "digit3_no_err", int'(bus0.err), 0);
    idle(1);
    chk(0, "digit4_err", int'(bus0.err), 1);
    chk(0, "digit4_code", int'(bus0.err_code), 3);

    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("2 2 5 6 ");
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("1 1 7 ");
    idle(2);
    chk(0, "rst_new_rows", int'(bus0.mat_out.rows), 1);
    chk(0, "rst_new_cell00", int'(bus0.mat_out.cells[0][0]), 7);
    chk(0, "rst_new_cell01", int'(bus0.mat_out.cells[0][1]), 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("2 2 5 6 ");
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);
    chk(0, "abort_busy", int'(bus0.busy), 0);
    chk(0, "abort_err_code", int'(bus0.err_code), 0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h39);
    send("1 1 7 ");
    idle(2);
    chk(0, "abort_new_cols", int'(bus0.mat_out.cols), 1);
    chk(0, "abort_new_cell00", int'(bus0.mat_out.cells[0][0]), 7);
    chk(0, "abort_new_cell01", int'(bus0.mat_out.cells[0][1]), 0);

    for (int m = 0; m < 200; m++) run_random_msg();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_input_parser.md
MATRIX_INPUT_PARSER -- requirements
Module: matrix_input_parser

Interface
REQ-001 Parameter MAX_ROWS, default 5, maximum accepted row count.
REQ-002 Parameter MAX_COLS, default 5, maximum accepted column count.
REQ-003 Parameter VAL_MIN, default 0, minimum accepted element value (signed).
REQ-004 Parameter VAL_MAX, default 9, maximum accepted element value (signed, VAL_MAX <= 127, VAL_MIN >= -128).
REQ-005 clk  input  1  system clock, 100 MHz; single clock domain.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  single-cycle pulse; begins a new matrix entry.
REQ-008 abort  input  1  single-cycle pulse; cancels the entry in progress.
REQ-009 rx_valid  input  1  one-cycle strobe from the UART receiver; rx_data is valid.
REQ-010 rx_data  input  8  received ASCII byte.
REQ-011 mat_out  output  matrix_t  assembled matrix (rows, cols, is_valid, cells).
REQ-012 mat_valid  output  1  one-cycle pulse; mat_out is complete.
REQ-013 busy  output  1  high from start until completion, error or abort.
REQ-014 err  output  1  one-cycle pulse on a parse error.
REQ-015 err_code  output  2  error cause: 0 none, 1 ERR_DIM, 2 ERR_CHAR, 3 ERR_RANGE; held until the next start.

Function
REQ-016 The FSM states SHALL be IDLE, GET_ROWS, GET_COLS, GET_ELEMS, DONE and ERROR.
REQ-017 Transitions: start -> GET_ROWS; first token -> GET_COLS; second token -> GET_ELEMS; last element or LF -> DONE; any error -> ERROR; DONE and ERROR each last one cycle, then IDLE.
REQ-018 Token grammar: an optional '-' followed by 1-3 digits '0'-'9'.
REQ-019 Delimiters: space (0x20) and CR (0x0D) close a pending token; when no token is pending they are ignored.
REQ-020 LF (0x0A) closes a pending token; in GET_ELEMS it also ends the matrix.
REQ-021 In GET_ROWS or GET_COLS, LF with no complete dimension SHALL be ignored.
REQ-022 Magnitude is accumulated in a 10-bit unsigned register (acc*10 + digit); the signed value is formed at 11 bits and compared against the limits.
REQ-023 A dimension outside 1..MAX_ROWS (rows) or 1..MAX_COLS (cols), or a dimension carrying '-', SHALL raise ERR_DIM.
REQ-024 An element outside VAL_MIN..VAL_MAX, or a token of 4 or more digits, SHALL raise ERR_RANGE; the error fires on the 4th digit.
REQ-025 Any other byte, '-' not at token start, or '-' followed by a delimiter SHALL raise ERR_CHAR.
REQ-026 Elements SHALL be stored row-major into cells[r][c] as 8-bit two's complement; c wraps to 0 and r increments at c == cols-1.
REQ-027 After rows*cols elements, mat_valid SHALL pulse; subsequent bytes until the next start are ignored.
REQ-028 An LF in GET_ELEMS with at least one stored element SHALL complete the matrix; unreceived cells remain 0.
REQ-029 An LF in GET_ELEMS with zero elements stored SHALL be ignored.
REQ-030 Cells outside rows x cols SHALL be 0; is_valid SHALL be 1 when mat_valid pulses.
REQ-031 Latency: mat_valid or err SHALL assert in the cycle after the rx_valid beat that caused it.
REQ-032 mat_out SHALL stay stable from the mat_valid pulse until the next start.
REQ-033 rx_valid while in IDLE SHALL be ignored.
REQ-034 start while busy SHALL restart the entry: cells are zeroed, err_code is cleared and the FSM enters GET_ROWS.
REQ-035 start coincident with rx_valid SHALL act as the restart only; that byte is dropped.
REQ-036 abort SHALL return the FSM to IDLE without mat_valid or err; mat_out is left unchanged.
REQ-037 If start and abort coincide, start SHALL win.
REQ-038 On error, mat_valid SHALL NOT pulse and the partial matrix SHALL keep is_valid = 0.

Reset
REQ-039 rst SHALL force IDLE, mat_out to all-zero (is_valid 0), mat_valid 0, busy 0, err 0, err_code 0, and clear the accumulator and indices.
REQ-040 rst SHALL take priority over start, abort and rx_valid in the same cycle; rst mid-entry discards all progress.

Verification
REQ-041 start; "2 3 1 2 3 4 5 6 " -> one mat_valid; rows 2, cols 3, cells[1][2] = 6, all other cells outside 2x3 = 0, is_valid 1.
REQ-042 start; "3 3 1 2\n" -> mat_valid; cells[0][0] = 1, cells[0][1] = 2, remaining cells 0.
REQ-043 start; "6 " -> err pulse with err_code 1, busy low; start; "0 " -> err_code 1.
REQ-044 start; "1 1 12 " with defaults -> err_code 3; with VAL_MIN = -3, start; "1 1 -3\n" -> cells[0][0] = 8'hFD.
REQ-045 start; "2 2 1a" -> err_code 2 on 'a'; start; "1 1 1000" -> err_code 3 on the 4th digit.
REQ-046 rst or abort mid-entry, then start; "1 1 7 " -> no stale data; rows 1, cols 1, cells[0][0] = 7.
